// File: rtl/itch_message_dispatcher.sv
// ITCH framing stage: splits the 64-bit beat stream into length-prefixed messages and emits
// per-type start pulses. Define ITCH_MAX_LEN_CHECK_EN to flag lengths above MAX_LEN.
module itch_message_dispatcher #(
   parameter logic [7:0]  TICK_TYPE = 8'h4C,
   parameter logic [15:0] MAX_LEN   = 16'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] dataIn,
   input  logic        validIn,
   output logic        readyOut,
   output logic [63:0] dataOut,
   output logic [5:0]  trackerOut,
   output logic [7:0]  msgType,
   output logic        startTickSizeTableEntry,
   output logic        startOther,
   output logic        payloadValid,
   output logic        lastOut,
   output logic        errorOut
);

   typedef enum logic [1:0] {StHdr0, StHdr1, StType, StBody} state_e;

   state_e      state_q, state_d;
   logic [2:0]  ptr_q, ptr_d;
   logic [15:0] rem_q, rem_d;
   logic [7:0]  len_hi_q, len_hi_d;
   logic        first_q, first_d;
   logic        skip_q, skip_d;
   logic        ready_q, ready_d;
   logic [63:0] data_q, data_d;
   logic [5:0]  tracker_q, tracker_d;
   logic [7:0]  type_q, type_d;
   logic        tick_q, tick_d;
   logic        other_q, other_d;
   logic        pv_q, pv_d;
   logic        last_q, last_d;
   logic        err_q, err_d;

   logic [63:0] beat_v;
   logic        proc_v;
   logic [2:0]  start_v;
   logic        stop_v;
   logic [3:0]  end_v;
   logic [7:0]  byte_v;
   logic [15:0] len_v;
   logic        over_v;

`ifndef ITCH_MAX_LEN_CHECK_EN
   logic unused_max_len;
   assign unused_max_len = ^MAX_LEN;
`endif

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      len_hi_d  = len_hi_q;
      first_d   = first_q;
      skip_d    = skip_q;
      ready_d   = ready_q;
      data_d    = data_q;
      type_d    = type_q;
      tracker_d = 6'd0;
      tick_d    = 1'b0;
      other_d   = 1'b0;
      pv_d      = 1'b0;
      last_d    = 1'b0;
      err_d     = 1'b0;
      // A held beat lives in data_q and is re-processed regardless of validIn.
      beat_v    = ready_q ? dataIn : data_q;
      proc_v    = validIn | ~ready_q;
      start_v   = ready_q ? 3'd0 : ptr_q;
      stop_v    = 1'b0;
      end_v     = 4'd8;
      byte_v    = 8'd0;
      len_v     = 16'd0;
      over_v    = 1'b0;
      if (proc_v) begin
         data_d = beat_v;
         for (int i = 0; i < 8; i++) begin
            if (!stop_v && (3'(i) >= start_v)) begin
               byte_v = beat_v[8*i +: 8];
               unique case (state_d)
                  StHdr0: begin
                     len_hi_d = byte_v;
                     state_d  = StHdr1;
                  end
                  StHdr1: begin
                     len_v = {len_hi_d, byte_v};
`ifdef ITCH_MAX_LEN_CHECK_EN
                     over_v = (len_v > MAX_LEN);
`else
                     over_v = 1'b0;
`endif
                     if (len_v == 16'd0) begin
                        err_d   = 1'b1;
                        state_d = StHdr0;
                        stop_v  = 1'b1;
                        end_v   = 4'(i + 1);
                     end else begin
                        rem_d   = len_v - 16'd1;
                        skip_d  = over_v;
                        err_d   = over_v;
                        state_d = StType;
                     end
                  end
                  StType: begin
                     type_d = byte_v;
                     if (rem_d == 16'd0) begin
                        tick_d  = !skip_d && (byte_v == TICK_TYPE);
                        other_d = !skip_d && (byte_v != TICK_TYPE);
                        last_d  = !skip_d;
                        state_d = StHdr0;
                        stop_v  = 1'b1;
                        end_v   = 4'(i + 1);
                     end else begin
                        first_d = 1'b1;
                        state_d = StBody;
                     end
                  end
                  StBody: begin
                     if (!skip_d && !pv_d) begin
                        pv_d      = 1'b1;
                        tracker_d = 6'(8 * i);
                     end
                     if (first_d) begin
                        first_d = 1'b0;
                        tick_d  = !skip_d && (type_d == TICK_TYPE);
                        other_d = !skip_d && (type_d != TICK_TYPE);
                     end
                     rem_d = rem_d - 16'd1;
                     if (rem_d == 16'd0) begin
                        last_d  = !skip_d;
                        state_d = StHdr0;
                        stop_v  = 1'b1;
                        end_v   = 4'(i + 1);
                     end
                  end
                  default: state_d = StHdr0;
               endcase
            end
         end
         // Hold the beat only when a message ended with bytes still left in it.
         ready_d = !(stop_v && (end_v != 4'd8));
         ptr_d   = ready_d ? 3'd0 : end_v[2:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StHdr0;
         ptr_q     <= 3'd0;
         rem_q     <= 16'd0;
         len_hi_q  <= 8'd0;
         first_q   <= 1'b0;
         skip_q    <= 1'b0;
         ready_q   <= 1'b1;
         data_q    <= 64'd0;
         tracker_q <= 6'd0;
         type_q    <= 8'd0;
         tick_q    <= 1'b0;
         other_q   <= 1'b0;
         pv_q      <= 1'b0;
         last_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         len_hi_q  <= len_hi_d;
         first_q   <= first_d;
         skip_q    <= skip_d;
         ready_q   <= ready_d;
         data_q    <= data_d;
         tracker_q <= tracker_d;
         type_q    <= type_d;
         tick_q    <= tick_d;
         other_q   <= other_d;
         pv_q      <= pv_d;
         last_q    <= last_d;
         err_q     <= err_d;
      end
   end

   assign readyOut                = ready_q;
   assign dataOut                 = data_q;
   assign trackerOut              = tracker_q;
   assign msgType                 = type_q;
   assign startTickSizeTableEntry = tick_q;
   assign startOther              = other_q;
   assign payloadValid            = pv_q;
   assign lastOut                 = last_q;
   assign errorOut                = err_q;

endmodule

// File: doc/itch_message_dispatcher.md
# itch_message_dispatcher

Upstream framing stage of the ITCH parser chain. It takes the raw 64-bit beat stream, finds each message from its 2-byte length prefix and 1-byte type, and forwards each beat with a bit-offset tracker and a per-type start pulse. The message parsers downstream (tick-size-table-entry parser and siblings) consume those beats. It also owns back-pressure when two messages share one beat.

## Interface
Parameters:
- `TICK_TYPE`, 8'h4C: type byte ('L') that routes to the tick-size-table-entry parser.
- `MAX_LEN`, 16'd64: largest legal length field; only used when the length check is compiled in.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `dataIn` in 64: input beat; byte k occupies `dataIn[8k+7:8k]`.
- `validIn` in 1: `dataIn` is valid.
- `readyOut` out 1: beat is accepted on a cycle when `validIn & readyOut`.
- `dataOut` out 64: registered copy of the beat being processed.
- `trackerOut` out 6: bit offset (8 × byte index) of the first payload byte in `dataOut`.
- `msgType` out 8: type byte of the current message.
- `startTickSizeTableEntry` out 1: start pulse for a `TICK_TYPE` message.
- `startOther` out 1: start pulse for any other type.
- `payloadValid` out 1: `dataOut` holds at least one payload byte of the current message.
- `lastOut` out 1: `dataOut` holds the final byte of the current message.
- `errorOut` out 1: one-cycle pulse on a framing error.

## Operation
- Message framing: LEN_HI, then LEN_LO (big-endian), then TYPE, then LEN−1 payload bytes. LEN counts the type byte plus the payload.
- FSM states:
  - HDR0 (expect LEN_HI).
  - HDR1 (expect LEN_LO).
  - TYPE.
  - BODY, with a `remaining[15:0]` counter.
- Internal `bytePtr[2:0]` marks the next unconsumed byte of the held beat.
- Each processing cycle starts at `bytePtr`. It consumes any pending header bytes, then payload bytes of at most one message. It stops at the end of the beat or the end of the message, whichever comes first.
- Two messages in one beat: if the message ends with bytes left in the beat, the beat is held.
  - `readyOut` is 0 on the next cycle.
  - The held beat is re-processed from the new `bytePtr`.
  - This repeats until the beat is exhausted.
- Headers may straddle beats; the FSM carries header state across beats.
- Start pulses:
  - The pulse for the message fires on the output beat containing its first payload byte, with `trackerOut` set to that byte's offset.
  - The pulse is `startTickSizeTableEntry` if the type equals `TICK_TYPE`, else `startOther`. Exactly one of the two fires.
  - If LEN==1 (no payload), the start pulse and `lastOut` fire on the type beat, with `payloadValid`=0 and `trackerOut`=0.
- `msgType` holds its value until the next TYPE byte is consumed.
- LEN==0: `errorOut` pulses and no start pulse fires. Only the 2 length bytes are consumed; the next byte is treated as a new LEN_HI.
- Idle bubbles (`validIn`=0) never change state; outputs other than `dataOut` and `msgType` deassert.

## Timing
- Latency is 1 cycle: outputs for an accepted (or re-processed) beat appear in the register the next cycle.
- One beat processing per cycle. Throughput is 1 beat/cycle, except one extra cycle for each additional message that starts inside an already-held beat.
- Reset values:
  - `readyOut`=1.
  - `dataOut`, `trackerOut`, `msgType`, all pulses, `payloadValid` and `lastOut` = 0.
  - FSM = HDR0, `bytePtr`=0, `remaining`=0.
- Reset mid-message or mid-hold: the held beat is discarded and framing restarts at byte 0 of the next accepted beat.
- `readyOut` is combinationally independent of `validIn`. It is registered and deasserts only while a held beat still has unconsumed bytes.
- `remaining` is 16-bit and never wraps; payload bytes beyond the counter are never attributed to the message.

## Configuration
- `ITCH_MAX_LEN_CHECK_EN`, defined: LEN > `MAX_LEN` pulses `errorOut` when LEN_LO is consumed.
  - The message is still framed (LEN bytes skipped) but produces no start pulse and `payloadValid`/`lastOut` stay 0.
- Undefined: any LEN from 1 to 65535 is accepted; only LEN==0 is an error.

## Test plan
- Reset: assert `rst` async mid-cycle → `readyOut`=1 and all other outputs 0 immediately.
- Tick message, LEN=0x0019: beat0 = {00,19,4C,5 payload}, beats 1–2 = 8 payload each, beat3 = {3 payload, 5 bytes of next header}.
  - Beat0 output: `startTickSizeTableEntry`=1, `trackerOut`=24, `msgType`=8'h4C.
  - Beat3 output: `lastOut`=1 and `readyOut`=0 for one cycle.
  - The held beat is then re-processed from byte 3.
- Back-to-back tiny messages: one beat holding {00,02,41,xx,00,02,42,yy} → two `startOther` pulses on consecutive cycles.
  - `trackerOut` = 24 then 56.
  - `msgType` = 8'h41 then 8'h42.
  - `readyOut` is low for exactly 1 cycle.
- Header straddle: LEN_HI as byte 7 of beat n, LEN_LO and TYPE as bytes 0–1 of beat n+1 → start pulse on beat n+1 with `trackerOut`=16.
- LEN=0: {00,00,00,01,4C,...} → `errorOut` pulses once, then LEN=1 message yields a start pulse together with `lastOut`.
- With `ITCH_MAX_LEN_CHECK_EN`, `MAX_LEN`=64: LEN=0x0041 → `errorOut` pulse and no start pulse. The following message is framed correctly 65 bytes later.
